// File: rtl/shift_arbiter_if.sv
// Handshake bundle between two shift requesters, the result consumer and shift_arbiter.
interface shift_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AMT_W  = 4
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic [AMT_W-1:0]  req0_amt;
  logic              req0_mode;
  logic              req0_ready;

  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic [AMT_W-1:0]  req1_amt;
  logic              req1_mode;
  logic              req1_ready;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_id;

  modport master (
    output req0_valid, req0_data, req0_amt, req0_mode,
    output req1_valid, req1_data, req1_amt, req1_mode,
    output res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_mode,
    input  req1_valid, req1_data, req1_amt, req1_mode,
    input  res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 16-bit SLL/SRA barrel shifter between two requesters,
// returning a tagged result under a valid/ready handshake.
module shift_arbiter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned AMT_W     = 4,
  parameter bit          LAST_INIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state;
  logic              last;
  logic [DATA_W-1:0] op_data;
  logic [AMT_W-1:0]  op_amt;
  logic              op_mode;
  logic              op_id;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_id;

  logic              gnt0_c;
  logic              gnt1_c;
  logic [DATA_W-1:0] shift_c;

  // Grant only from IDLE; on a tie the requester that did not win last time goes first.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst_n && (state == IDLE)) begin
      if (bus.req0_valid && (!bus.req1_valid || last)) begin
        gnt0_c = 1'b1;
      end else if (bus.req1_valid) begin
        gnt1_c = 1'b1;
      end
    end
  end

  // Shared shifter driven from the captured operand.
  always_comb begin
    shift_c = op_data << op_amt;
    if (op_mode) begin
      shift_c = DATA_W'($signed(op_data) >>> op_amt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= LAST_INIT;
      op_data   <= '0;
      op_amt    <= '0;
      op_mode   <= 1'b0;
      op_id     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0_c || gnt1_c) begin
            op_data <= gnt1_c ? bus.req1_data : bus.req0_data;
            op_amt  <= gnt1_c ? bus.req1_amt  : bus.req0_amt;
            op_mode <= gnt1_c ? bus.req1_mode : bus.req0_mode;
            op_id   <= gnt1_c;
            last    <= gnt1_c;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= shift_c;
          res_id    <= op_id;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Result stays parked until the consumer takes it.
          if (res_valid && bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = gnt0_c;
  assign bus.req1_ready = gnt1_c;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = res_data;
  assign bus.res_id     = res_id;

endmodule
